fft_frame_scheduler: RTL

Frame-level sequencer between the microphone sample stream, the FFT controller and the VGA display path. Captures 2**ADDR_WIDTH decimated samples into the FFT buffer through the controller's mic write port, issues a one-cycle start, waits for the transform to finish, then holds the result stable for a programmable number of VGA frames before capturing again. Samples arriving while the buffer is owned by the FFT or the display are counted as drops.

---
 rtl/fft_frame_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer: captures one decimated frame into the FFT buffer, starts the
// transform, waits for completion, then holds the spectrum for HOLD_FRAMES vsyncs.
module fft_frame_scheduler #(
    parameter int DATA_WIDTH   = 18,
    parameter int SAMPLE_WIDTH = 12,
    parameter int ADDR_WIDTH   = 4,
    parameter int DECIMATE     = 1,
    parameter int HOLD_FRAMES  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture_en,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    fft_done,
    input  logic                    vsync,
    output logic                    mic_we,
    output logic [ADDR_WIDTH-1:0]   mic_addr,
    output logic [DATA_WIDTH-1:0]   mic_data,
    output logic                    fft_start,
    output logic                    frame_ready,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    localparam int DEC_W  = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [DEC_W-1:0]      DEC_LAST  = DEC_W'(DECIMATE - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   sample_idx;
    logic [DEC_W-1:0]        dec_cnt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    vsync_q;
    logic                    vsync_rise;
    logic                    keep;
    logic                    drop;

    assign vsync_rise = vsync & ~vsync_q;
    assign keep       = (state == S_CAPTURE) && sample_valid && (dec_cnt == '0);
    assign drop       = sample_valid && (state inside {S_START, S_WAIT_ACK, S_WAIT_DONE, S_HOLD});

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (capture_en) state_next = S_CAPTURE;
            S_CAPTURE:   if (keep && sample_idx == ADDR_LAST) state_next = S_START;
            S_START:     state_next = S_WAIT_ACK;
            // done is a level: wait for it to drop first so a stale 1 is not taken as completion
            S_WAIT_ACK:  if (!fft_done) state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (fft_done) state_next = S_HOLD;
            S_HOLD:      if (vsync_rise && hold_cnt == HOLD_LAST)
                             state_next = capture_en ? S_CAPTURE : S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_idx  <= '0;
            dec_cnt     <= '0;
            hold_cnt    <= '0;
            vsync_q     <= 1'b0;
            mic_we      <= 1'b0;
            mic_addr    <= '0;
            mic_data    <= '0;
            fft_start   <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            drop_count  <= '0;
        end else begin
            vsync_q     <= vsync;
            mic_we      <= keep;
            fft_start   <= (state == S_START);
            frame_ready <= (state == S_WAIT_DONE) && fft_done;
            busy        <= (state_next != S_IDLE);

            if (keep) begin
                mic_addr <= sample_idx;
                mic_data <= DATA_WIDTH'($signed(sample_data));
            end

            // Counters sit at zero outside CAPTURE, so every capture starts from index 0.
            if (state == S_CAPTURE) begin
                if (sample_valid) begin
                    dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DEC_W'(1);
                    if (keep) sample_idx <= sample_idx + ADDR_WIDTH'(1);
                end
            end else begin
                sample_idx <= '0;
                dec_cnt    <= '0;
            end

            if (state == S_HOLD) begin
                if (vsync_rise) hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end

            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule
